add_sub_norm: RTL
=================

ADD_SUB_NORM -- requirements
Module: add_sub_norm

Interface
REQ-001 The block SHALL have one clock, clk (input, 1): all state changes on its rising edge.
REQ-002 The block SHALL have one reset, rst_n (input, 1): asynchronous, active-low.
REQ-003 in_valid (input, 1): operand set on inputs is valid.
REQ-004 in_ready (output, 1): block accepts operands this cycle.
REQ-005 fracta (input, 27): pre-normalized fraction A; [26] hidden bit, [2:0] guard/round/sticky.
REQ-006 fractb (input, 27): pre-normalized fraction B, same alignment as fracta.
REQ-007 exp_in (input, 8): common exponent from pre-normalization.
REQ-008 sign_in (input, 1): result sign selected by pre-normalization.
REQ-009 fasu_op (input, 1): 1 = add fractions, 0 = subtract.
REQ-010 out_valid (output, 1): result outputs valid.
REQ-011 out_ready (input, 1): consumer takes the result this cycle.
REQ-012 fract_out (output, 27): normalized result fraction.
REQ-013 exp_out (output, 8): adjusted exponent.
REQ-014 sign_out (output, 1): result sign.
REQ-015 zero, overflow, underflow (outputs, 1 each): result flags.
REQ-016 norm_shift (output, 5): number of left shifts applied.

Function
REQ-017 The FSM SHALL have states IDLE, CALC, NORM, DONE; in_ready=1 only in IDLE.
REQ-018 IDLE: on in_valid=1, capture all inputs and go to CALC; otherwise stay in IDLE.
REQ-019 CALC (1 cycle), add: sum[27:0] = fracta + fractb; sign = sign_in.
REQ-020 CALC, subtract with fracta >= fractb: res = fracta - fractb; sign = sign_in.
REQ-021 CALC, subtract with fracta < fractb: res = fractb - fracta; sign = ~sign_in.
REQ-022 CALC, carry (sum[27]=1): res = sum[27:1] with res[0] |= sum[0] (sticky); exp = exp_in+1; go to DONE.
REQ-023 Carry with exp_in >= 0xFE: exp_out = 0xFF, overflow=1 (saturated, no wrap).
REQ-024 CALC, result == 0: fract_out=0, exp_out=0, sign_out=0, zero=1; go to DONE.
REQ-025 CALC, all other results: go to NORM with norm_shift=0.
REQ-026 NORM, res[26]=1: go to DONE.
REQ-027 NORM, res[26]=0 and exp > 1: res <<= 1 (zero fill); exp -= 1; norm_shift += 1; stay in NORM; one shift per cycle.
REQ-028 NORM, res[26]=0 and exp <= 1: exp_out=0, underflow=1, no shift; go to DONE.
REQ-029 DONE: out_valid=1 with outputs held stable until out_ready=1; on that cycle go to IDLE.
REQ-030 in_valid SHALL be ignored outside IDLE.
REQ-031 Latency, accepting edge to first out_valid cycle: 2 cycles for carry or zero; 3+k cycles for k normalization shifts (k <= 26).
REQ-032 The maximum latency SHALL be 29 cycles.
REQ-033 Results and flags SHALL change only on leaving CALC/NORM; flags clear on each acceptance.

Reset
REQ-034 When rst_n=0, the FSM SHALL go to IDLE immediately, regardless of clk.
REQ-035 Reset values: out_valid=0, in_ready=1 once in IDLE, fract_out=0, exp_out=0, sign_out=0, zero=0, overflow=0, underflow=0, norm_shift=0.
REQ-036 Reset during CALC/NORM/DONE SHALL discard the operation; no out_valid follows.

Verification
REQ-037 Add carry: fracta=fractb=0x4000000, exp_in=0x80, fasu_op=1, sign_in=0 -> fract_out=0x4000000, exp_out=0x81, sign_out=0, norm_shift=0, out_valid 2 cycles after acceptance.
REQ-038 Subtract with normalization: fracta=0x4000000, fractb=0x3000000, exp_in=0x80, fasu_op=0 -> fract_out=0x4000000, exp_out=0x7E, norm_shift=2, out_valid 5 cycles after acceptance.
REQ-039 Swapped subtract: fracta=0x3000000, fractb=0x4000000, sign_in=0 -> sign_out=1, fract_out=0x4000000, exp_out=0x7E; equal operands -> zero=1, fract_out=0, exp_out=0.
REQ-040 Overflow and underflow:
  - Carry with exp_in=0xFE -> exp_out=0xFF, overflow=1.
  - Subtract 0x4000000-0x3000000 with exp_in=0x01 -> exp_out=0, underflow=1, norm_shift=0.
REQ-041 Backpressure: out_ready=0 for 5 cycles in DONE -> outputs held, in_ready=0, in_valid pulses ignored; then out_ready=1 -> IDLE next cycle.
REQ-042 Reset mid-NORM: rst_n low during REQ-038 shifting -> out_valid=0 and all outputs 0 at once, in_ready=1 after release.

Source files
------------

// File: rtl/add_sub_norm.sv
// Fraction add/subtract with post-normalization for a pre-aligned FP datapath.
// One normalization shift per cycle; the result is held in DONE until the consumer takes it.
module add_sub_norm (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [26:0] fracta,
    input  logic [26:0] fractb,
    input  logic [7:0]  exp_in,
    input  logic        sign_in,
    input  logic        fasu_op,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [26:0] fract_out,
    output logic [7:0]  exp_out,
    output logic        sign_out,
    output logic        zero,
    output logic        overflow,
    output logic        underflow,
    output logic [4:0]  norm_shift
);
    typedef enum logic [1:0] {IDLE, CALC, NORM, DONE} state_t;

    state_t      state_q, state_d;
    logic [26:0] fa_q, fa_d, fb_q, fb_d, res_q, res_d;
    logic [7:0]  exp_q, exp_d;
    logic        sign_q, sign_d, op_q, op_d;
    logic [4:0]  shift_q, shift_d;
    logic [26:0] fract_q, fract_d;
    logic [7:0]  expo_q, expo_d;
    logic        signo_q, signo_d, zero_q, zero_d, ovf_q, ovf_d, unf_q, unf_d;
    logic [4:0]  nsh_q, nsh_d;

    logic [27:0] raw;
    logic        raw_sign;

    // Magnitude of the operation; a swapped subtract flips the result sign.
    always_comb begin
        raw      = {1'b0, fa_q} + {1'b0, fb_q};
        raw_sign = sign_q;
        if (!op_q) begin
            if (fa_q >= fb_q) begin
                raw = {1'b0, fa_q - fb_q};
            end else begin
                raw      = {1'b0, fb_q - fa_q};
                raw_sign = ~sign_q;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        fa_d    = fa_q;
        fb_d    = fb_q;
        res_d   = res_q;
        exp_d   = exp_q;
        sign_d  = sign_q;
        op_d    = op_q;
        shift_d = shift_q;
        fract_d = fract_q;
        expo_d  = expo_q;
        signo_d = signo_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        nsh_d   = nsh_q;
        unique case (state_q)
            IDLE: if (in_valid) begin
                fa_d    = fracta;
                fb_d    = fractb;
                exp_d   = exp_in;
                sign_d  = sign_in;
                op_d    = fasu_op;
                zero_d  = 1'b0;
                ovf_d   = 1'b0;
                unf_d   = 1'b0;
                state_d = CALC;
            end
            CALC: begin
                if (raw[27]) begin
                    // Carry out: shift right once, folding the dropped bit into sticky.
                    fract_d = {raw[27:2], raw[1] | raw[0]};
                    expo_d  = (exp_q >= 8'hFE) ? 8'hFF : exp_q + 8'd1;
                    ovf_d   = (exp_q >= 8'hFE);
                    signo_d = raw_sign;
                    nsh_d   = 5'd0;
                    state_d = DONE;
                end else if (raw == 28'd0) begin
                    fract_d = 27'd0;
                    expo_d  = 8'd0;
                    signo_d = 1'b0;
                    zero_d  = 1'b1;
                    nsh_d   = 5'd0;
                    state_d = DONE;
                end else begin
                    res_d   = raw[26:0];
                    sign_d  = raw_sign;
                    shift_d = 5'd0;
                    state_d = NORM;
                end
            end
            NORM: begin
                if (res_q[26] || exp_q <= 8'd1) begin
                    fract_d = res_q;
                    expo_d  = res_q[26] ? exp_q : 8'd0;
                    unf_d   = ~res_q[26];
                    signo_d = sign_q;
                    nsh_d   = shift_q;
                    state_d = DONE;
                end else begin
                    res_d   = {res_q[25:0], 1'b0};
                    exp_d   = exp_q - 8'd1;
                    shift_d = shift_q + 5'd1;
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            fa_q    <= '0;
            fb_q    <= '0;
            res_q   <= '0;
            exp_q   <= '0;
            sign_q  <= 1'b0;
            op_q    <= 1'b0;
            shift_q <= '0;
            fract_q <= '0;
            expo_q  <= '0;
            signo_q <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            nsh_q   <= '0;
        end else begin
            state_q <= state_d;
            fa_q    <= fa_d;
            fb_q    <= fb_d;
            res_q   <= res_d;
            exp_q   <= exp_d;
            sign_q  <= sign_d;
            op_q    <= op_d;
            shift_q <= shift_d;
            fract_q <= fract_d;
            expo_q  <= expo_d;
            signo_q <= signo_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            nsh_q   <= nsh_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign fract_out  = fract_q;
    assign exp_out    = expo_q;
    assign sign_out   = signo_q;
    assign zero       = zero_q;
    assign overflow   = ovf_q;
    assign underflow  = unf_q;
    assign norm_shift = nsh_q;
endmodule
